// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM of the multicycle MIPS core. One instruction at a time
//   is sequenced through fetch, decode, execute, memory and writeback.
//   Memory states wait on mem_ready, so single- or multi-cycle memories work.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   Upcode[5:0]   opcode from the instruction register (read in DECODE/MEMADR)
//   mem_ready     memory finishes the current access this cycle
//   IRWrite, PCWrite, Branch, IorD, MemRead, MemWrite, RegWrite, RegDst,
//   MemtoReg, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]
//                 datapath controls (Moore, except IRWrite/PCWrite in FETCH)
//   instr_done    one-cycle pulse as an instruction retires
//   illegal_op    one-cycle pulse in DECODE for an unsupported opcode
//   state_dbg     current state code
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Upcode,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQEX  = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JEX    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state, next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= next;
    end

    assign state_dbg = state;

    always_comb begin
        next       = S_FETCH;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_RESET: next = S_FETCH;

            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but IR and PC only load
                // in the cycle the memory actually returns the word.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                next    = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // ALU precomputes PC + (imm << 2) for a possible beq.
                ALUSrcB = 2'b11;
                case (Upcode)
                    OP_RTYPE:     next = S_RTEX;
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_BEQ:       next = S_BEQEX;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_J:         next = S_JEX;
                    default: begin
                        next       = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = (Upcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end

            S_MEMWR: begin
                // A store retires the cycle memory accepts it.
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                next       = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                next    = S_RTWB;
            end

            S_RTWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end

            S_BEQEX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
                instr_done = 1'b1;
            end

            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = S_ADDIWB;
            end

            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end

            S_JEX: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end

            // Unused codes recover to FETCH with all outputs idle.
            default: next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a directed table of per-cycle vectors for
// the named corner cases, then random opcodes / mem_ready against a model
// that plays out each instruction as a list of steps.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Upcode;
    logic       mem_ready;
    logic       IRWrite, PCWrite, Branch, IorD, MemRead, MemWrite;
    logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       instr_done, illegal_op;
    logic [3:0] state_dbg;

    int nvec = 0;
    int nerr = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Upcode(Upcode), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .instr_done(instr_done), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {IRWrite, PCWrite, Branch, IorD, MemRead, MemWrite, RegWrite,
                   RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                   instr_done, illegal_op};

    function automatic bit legal(logic [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 ||
               op == 6'd4 || op == 6'd8  || op == 6'd2;
    endfunction

    // Expected control word for a state code, straight from the output table.
    function automatic logic [17:0] spec_out(int st, bit mr, logic [5:0] op);
        logic irw, pcw, br, iord, mrd, mwr, rw, rd, m2r, asa, dn, ill;
        logic [1:0] asb, aop, pcs;
        {irw, pcw, br, iord, mrd, mwr, rw, rd, m2r, asa, dn, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            2:  begin asb = 2'b11; ill = !legal(op); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin mwr = 1; iord = 1; dn = mr; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; dn = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; dn = 1; end
            12: begin pcw = 1; pcs = 2'b10; dn = 1; end
            default: ;
        endcase
        return {irw, pcw, br, iord, mrd, mwr, rw, rd, m2r, asa, asb, aop, pcs, dn, ill};
    endfunction

    task automatic check(string nm, int est, logic [17:0] eo);
        nvec++;
        if (state_dbg !== est[3:0] || outs !== eo) begin
            nerr++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     nm, state_dbg, outs, est, eo);
        end
    endtask

    // Steps after FETCH for an opcode, as state codes.
    function automatic void steps(logic [5:0] op, ref int q[$]);
        q.delete();
        q.push_back(2);
        case (op)
            6'd0:  begin q.push_back(7); q.push_back(8); end
            6'd35: begin q.push_back(3); q.push_back(4); q.push_back(5); end
            6'd43: begin q.push_back(3); q.push_back(6); end
            6'd4:  q.push_back(9);
            6'd8:  begin q.push_back(10); q.push_back(11); end
            6'd2:  q.push_back(12);
            default: ;
        endcase
    endfunction

    typedef struct {
        bit         rst_n;
        logic [5:0] op;
        bit         mr;
        int         st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit r, logic [5:0] op, bit mr, int st);
        vec_t v;
        v.rst_n = r; v.op = op; v.mr = mr; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        int cur, nxt;
        bit mr;
        logic [5:0] op;
        int plan[$];
        logic [5:0] ops[6];
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43;
        ops[3] = 6'd4; ops[4] = 6'd8;  ops[5] = 6'd2;

        // reset held 3 cycles, then release (state stays 0 until the edge)
        repeat (3) add(0, 6'd0, 1, 0);
        add(1, 6'd0, 1, 0);
        // R-type
        add(1, 6'd0, 1, 1); add(1, 6'd0, 1, 2); add(1, 6'd0, 1, 7); add(1, 6'd0, 1, 8);
        // lw with 2 stall cycles in MEMRD
        add(1, 6'd35, 1, 1); add(1, 6'd35, 1, 2); add(1, 6'd35, 1, 3);
        add(1, 6'd35, 0, 4); add(1, 6'd35, 0, 4); add(1, 6'd35, 1, 4); add(1, 6'd35, 1, 5);
        // sw with 1 stall cycle in FETCH
        add(1, 6'd43, 0, 1); add(1, 6'd43, 1, 1); add(1, 6'd43, 1, 2);
        add(1, 6'd43, 1, 3); add(1, 6'd43, 1, 6);
        // beq, j
        add(1, 6'd4, 1, 1); add(1, 6'd4, 1, 2); add(1, 6'd4, 1, 9);
        add(1, 6'd2, 1, 1); add(1, 6'd2, 1, 2); add(1, 6'd2, 1, 12);
        // addi, mem_ready ignored outside memory states
        add(1, 6'd8, 1, 1); add(1, 6'd8, 0, 2); add(1, 6'd8, 0, 10); add(1, 6'd8, 0, 11);
        // illegal opcode
        add(1, 6'd63, 1, 1); add(1, 6'd63, 1, 2);
        // sw stalled in MEMWR, then reset mid-store
        add(1, 6'd43, 1, 1); add(1, 6'd43, 1, 2); add(1, 6'd43, 1, 3);
        add(1, 6'd43, 0, 6); add(0, 6'd43, 0, 0); add(0, 6'd43, 1, 0);
        add(1, 6'd0, 1, 0); add(1, 6'd0, 1, 1);

        rst_n = 1'b0; Upcode = 6'd0; mem_ready = 1'b0;
        #1;
        check("async_reset", 0, 18'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; Upcode = tbl[i].op; mem_ready = tbl[i].mr;
            #1;
            check($sformatf("vec%0d", i), tbl[i].st, spec_out(tbl[i].st, tbl[i].mr, tbl[i].op));
        end

        // random phase
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cur = 0; op = 6'd0; mr = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            if (cur == 1)
                op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 5)]
                                                  : 6'($urandom_range(0, 63));
            mr = ($urandom_range(0, 3) != 0);
            Upcode = op; mem_ready = mr;
            #1;
            check("rand", cur, spec_out(cur, mr, op));
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_reset", 0, 18'd0);
                @(negedge clk);
                rst_n = 1'b1;
                cur = 0;
                plan.delete();
            end
            if (cur == 0)                                       nxt = 1;
            else if ((cur == 1 || cur == 4 || cur == 6) && !mr) nxt = cur;
            else if (cur == 1) begin steps(op, plan); nxt = plan.pop_front(); end
            else if (plan.size() > 0)                           nxt = plan.pop_front();
            else                                                nxt = 1;
            @(posedge clk);
            cur = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
